// File: rtl/inst_queue.sv
// inst_queue: dual-issue circular instruction queue between fetch and the two decode slots.
// Define INST_QUEUE_DELAY_SLOT_EN to keep the branch delay slot across a flush.
module inst_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid_1,
   input  logic        in_valid_2,
   input  logic [31:0] in_inst_1,
   input  logic [31:0] in_inst_2,
   input  logic [31:0] in_pc_1,
   input  logic [31:0] in_pc_2,
   input  logic [1:0]  in_exc_1,
   input  logic [1:0]  in_exc_2,
   output logic        in_ready,
   output logic        out_valid_1,
   output logic        out_valid_2,
   output logic [31:0] out_inst_1,
   output logic [31:0] out_inst_2,
   output logic [31:0] out_pc_1,
   output logic [31:0] out_pc_2,
   output logic [1:0]  out_exc_1,
   output logic [1:0]  out_exc_2,
   input  logic [1:0]  out_pop,
   input  logic        flush,
   output logic        ovf
);
   localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

   // Entry layout: {pc[65:34], inst[33:2], exc[1:0]}
   logic [65:0]      mem [DEPTH];
   logic [PTR_W-1:0] head, tail, head_nx, tail_nx, head_p1, tail_p1;
   logic [PTR_W:0]   count, count_nx, count_left;
   logic [1:0]       pop_req, pop_eff, push_n;
   logic             wr_1, wr_2;
   logic [65:0]      rd_1, rd_2;

   // in_ready looks only at the registered count, never at this cycle's pop.
   assign in_ready = !reset && (count <= READY_MAX);
   assign head_p1  = head + PTR_W'(1);
   assign tail_p1  = tail + PTR_W'(1);

   always_comb begin
      pop_req    = (out_pop == 2'd3) ? 2'd2 : out_pop;
      pop_eff    = (count < {{(PTR_W-1){1'b0}}, pop_req}) ? count[1:0] : pop_req;
      push_n     = (in_ready && in_valid_1) ? (in_valid_2 ? 2'd2 : 2'd1) : 2'd0;
      count_left = count - {{(PTR_W-1){1'b0}}, pop_eff};
      wr_1       = (push_n != 2'd0);
      wr_2       = (push_n == 2'd2);
      head_nx    = head + {{(PTR_W-2){1'b0}}, pop_eff};
      tail_nx    = tail + {{(PTR_W-2){1'b0}}, push_n};
      count_nx   = count_left + {{(PTR_W-1){1'b0}}, push_n};
      if (flush) begin
`ifdef INST_QUEUE_DELAY_SLOT_EN
         wr_2 = 1'b0;
         if (count_left != '0) begin
            // Oldest survivor of this cycle's pops is the delay slot.
            wr_1     = 1'b0;
            count_nx = (PTR_W+1)'(1);
            tail_nx  = head_nx + PTR_W'(1);
         end else if (push_n != 2'd0) begin
            head_nx  = tail;
            tail_nx  = tail_p1;
            count_nx = (PTR_W+1)'(1);
         end else begin
            head_nx  = '0;
            tail_nx  = '0;
            count_nx = '0;
         end
`else
         wr_1     = 1'b0;
         wr_2     = 1'b0;
         head_nx  = '0;
         tail_nx  = '0;
         count_nx = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_1) mem[tail]    <= {in_pc_1, in_inst_1, in_exc_1};
      if (wr_2) mem[tail_p1] <= {in_pc_2, in_inst_2, in_exc_2};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         head  <= head_nx;
         tail  <= tail_nx;
         count <= count_nx;
         ovf   <= in_valid_1 && !in_ready && !flush;
      end
   end

   assign rd_1        = mem[head];
   assign rd_2        = mem[head_p1];
   assign out_valid_1 = (count != '0);
   assign out_valid_2 = (count > (PTR_W+1)'(1));
   assign out_pc_1    = out_valid_1 ? rd_1[65:34] : '0;
   assign out_inst_1  = out_valid_1 ? rd_1[33:2]  : '0;
   assign out_exc_1   = out_valid_1 ? rd_1[1:0]   : '0;
   assign out_pc_2    = out_valid_2 ? rd_2[65:34] : '0;
   assign out_inst_2  = out_valid_2 ? rd_2[33:2]  : '0;
   assign out_exc_2   = out_valid_2 ? rd_2[1:0]   : '0;
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed plus randomized stimulus for inst_queue, checked against a
// queue-based reference model of the instruction queue.
module tb_inst_queue;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_1, in_valid_2;
   logic [31:0] in_inst_1, in_inst_2, in_pc_1, in_pc_2;
   logic [1:0]  in_exc_1, in_exc_2;
   logic        in_ready;
   logic        out_valid_1, out_valid_2;
   logic [31:0] out_inst_1, out_inst_2, out_pc_1, out_pc_2;
   logic [1:0]  out_exc_1, out_exc_2;
   logic [1:0]  out_pop;
   logic        flush;
   logic        ovf;

   int vecs = 0;
   int errs = 0;
   logic [65:0] exp_q[$];
   logic        exp_ovf = 1'b0;

   inst_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
      .clk(clk), .reset(reset),
      .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
      .in_inst_1(in_inst_1), .in_inst_2(in_inst_2),
      .in_pc_1(in_pc_1), .in_pc_2(in_pc_2),
      .in_exc_1(in_exc_1), .in_exc_2(in_exc_2),
      .in_ready(in_ready),
      .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
      .out_inst_1(out_inst_1), .out_inst_2(out_inst_2),
      .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
      .out_exc_1(out_exc_1), .out_exc_2(out_exc_2),
      .out_pop(out_pop), .flush(flush), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [65:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [1:0] exc);
      return {pc, inst, exc};
   endfunction

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      logic [65:0] e1, e2;
      e1 = (exp_q.size() >= 1) ? exp_q[0] : 66'd0;
      e2 = (exp_q.size() >= 2) ? exp_q[1] : 66'd0;
      chk({tag, ".valid_1"}, 66'(out_valid_1), 66'(exp_q.size() >= 1));
      chk({tag, ".valid_2"}, 66'(out_valid_2), 66'(exp_q.size() >= 2));
      chk({tag, ".slot_1"}, {out_pc_1, out_inst_1, out_exc_1}, e1);
      chk({tag, ".slot_2"}, {out_pc_2, out_inst_2, out_exc_2}, e2);
      chk({tag, ".ovf"}, 66'(ovf), 66'(exp_ovf));
   endtask

   // One clock of traffic: drive, check in_ready, clock, advance model, check outputs.
   task automatic step(input string tag, input logic v1, input logic v2,
                       input logic [65:0] d1, input logic [65:0] d2,
                       input logic [1:0] pop, input logic fl);
      logic ready_m;
      int   e, n, pop_lim;
      logic [65:0] keep;
      in_valid_1 = v1;  in_valid_2 = v2;
      {in_pc_1, in_inst_1, in_exc_1} = d1;
      {in_pc_2, in_inst_2, in_exc_2} = d2;
      out_pop = pop;  flush = fl;
      #1;
      ready_m = (exp_q.size() <= DEPTH - 2);
      chk({tag, ".in_ready"}, 66'(in_ready), 66'(ready_m));
      @(posedge clk);
      exp_ovf = v1 && !ready_m && !fl;
      pop_lim = (pop == 2'd3) ? 2 : int'(pop);
      e = (pop_lim < exp_q.size()) ? pop_lim : exp_q.size();
      for (int i = 0; i < e; i++) void'(exp_q.pop_front());
      if (fl) begin
`ifdef INST_QUEUE_DELAY_SLOT_EN
         if (exp_q.size() >= 1) begin
            keep = exp_q[0];
            exp_q.delete();
            exp_q.push_back(keep);
         end else if (v1 && ready_m) begin
            exp_q.push_back(d1);
         end
`else
         exp_q.delete();
`endif
      end else if (ready_m && v1) begin
         exp_q.push_back(d1);
         if (v2) exp_q.push_back(d2);
      end
      n = exp_q.size();
      #1;
      check_outs(tag);
      chk({tag, ".depth_model"}, 66'(n <= DEPTH), 66'(1));
   endtask

   task automatic idle(input string tag, input logic [1:0] pop);
      step(tag, 1'b0, 1'b0, 66'd0, 66'd0, pop, 1'b0);
   endtask

   task automatic push1(input string tag, input logic [31:0] pc);
      step(tag, 1'b1, 1'b0, mk(pc, $urandom, 2'($urandom)), 66'd0, 2'd0, 1'b0);
   endtask

   task automatic push2(input string tag, input logic [31:0] pc, input logic [1:0] pop);
      step(tag, 1'b1, 1'b1, mk(pc, $urandom, 2'($urandom)),
           mk(pc + 32'd4, $urandom, 2'($urandom)), pop, 1'b0);
   endtask

   initial begin
      logic [31:0] pc_second;
      reset = 1'b1;
      in_valid_1 = 0; in_valid_2 = 0; in_inst_1 = 0; in_inst_2 = 0;
      in_pc_1 = 0; in_pc_2 = 0; in_exc_1 = 0; in_exc_2 = 0;
      out_pop = 0; flush = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_ready", 66'(in_ready), 66'd0);
      check_outs("reset");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("release.in_ready", 66'(in_ready), 66'd1);

      // Two-entry push from reset
      step("tp1", 1'b1, 1'b1, mk(32'hbfc00000, 32'h24080001, 2'd0),
           mk(32'hbfc00004, 32'h24090002, 2'd0), 2'd0, 1'b0);
      chk("tp1.pc_1", 66'(out_pc_1), 66'(32'hbfc00000));
      chk("tp1.pc_2", 66'(out_pc_2), 66'(32'hbfc00004));

      // Fill to full, overflow attempt, then drain one to sit at 7
      push2("fill_4", 32'h100, 2'd0);
      push2("fill_6", 32'h108, 2'd0);
      push2("fill_8", 32'h110, 2'd0);
      chk("full.in_ready", 66'(in_ready), 66'd0);
      push1("ovf_push", 32'h200);
      chk("ovf.pulse", 66'(ovf), 66'd1);
      idle("ovf_clear", 2'd1);
      chk("ovf.cleared", 66'(ovf), 66'd0);
      push2("at7_push", 32'h300, 2'd0);
      chk("at7.ovf", 66'(ovf), 66'd1);

      // Empty, then steady push-2 / pop-2 through pointer wrap
      step("flush_empty", 1'b0, 1'b0, 66'd0, 66'd0, 2'd0, 1'b1);
      push2("ss_prime", 32'h0, 2'd0);
      for (int i = 1; i <= 20; i++) begin
         push2("steady", 32'(i * 8), 2'd2);
         chk("steady.pc_1", 66'(out_pc_1), 66'(32'(i * 8)));
      end

      // Pop 2 with a single entry present
      step("flush2", 1'b0, 1'b0, 66'd0, 66'd0, 2'd0, 1'b1);
      push1("one", 32'h400);
      idle("pop2_of_1", 2'd2);
      chk("pop2_of_1.inst_1", 66'(out_inst_1), 66'd0);
      idle("pop3_empty", 2'd3);

      // Flush with count 5 and one pop
      push2("c5_a", 32'h500, 2'd0);
      push2("c5_b", 32'h508, 2'd0);
      push1("c5_c", 32'h510);
      pc_second = exp_q[1][65:34];
      step("flush_c5", 1'b1, 1'b1, mk(32'h600, 0, 0), mk(32'h604, 0, 0), 2'd1, 1'b1);
`ifdef INST_QUEUE_DELAY_SLOT_EN
      chk("flush_c5.pc_1", 66'(out_pc_1), 66'(pc_second));
      chk("flush_c5.valid_2", 66'(out_valid_2), 66'd0);
`else
      chk("flush_c5.valid_1", 66'(out_valid_1), 66'd0);
`endif

      // Asynchronous reset mid-stream at count 6
      step("pre_rst_flush", 1'b0, 1'b0, 66'd0, 66'd0, 2'd0, 1'b1);
      push2("r6_a", 32'h700, 2'd0);
      push2("r6_b", 32'h708, 2'd0);
      push2("r6_c", 32'h710, 2'd0);
      in_valid_1 = 0; in_valid_2 = 0; out_pop = 0; flush = 0;
      #2;
      reset = 1'b1;
      exp_q.delete();
      exp_ovf = 1'b0;
      #1;
      chk("mid_rst.in_ready", 66'(in_ready), 66'd0);
      check_outs("mid_rst");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst.in_ready", 66'(in_ready), 66'd1);
      check_outs("post_rst");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom), 1'($urandom),
              mk($urandom, $urandom, 2'($urandom)), mk($urandom, $urandom, 2'($urandom)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
